// File: rtl/writeback_queue.sv
// Writeback stage: ALU/data-memory result select, small in-order retire queue
// driving the register-file write port, plus forwarding of pending results.
module writeback_queue #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sel,
    input  logic [DATA_W-1:0]            in_ans_alu,
    input  logic [DATA_W-1:0]            in_ans_dm,
    input  logic [ADDR_W-1:0]            in_rd,
    input  logic                         in_we,
    input  logic                         flush,
    output logic                         rf_we,
    input  logic                         rf_ready,
    output logic [ADDR_W-1:0]            rf_addr,
    output logic [DATA_W-1:0]            rf_data,
    input  logic [ADDR_W-1:0]            fwd_addr,
    output logic                         fwd_hit,
    output logic [DATA_W-1:0]            fwd_data,
    output logic [DATA_W-1:0]            ans_wb,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] rd_mem   [DEPTH];
    logic              we_mem   [DEPTH];
    logic [DEPTH-1:0]  vld;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              push;
    logic              pop;
    logic              wr_fire;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        else
            return p + 1'b1;
    endfunction

    assign in_ready  = (count < CNT_W'(DEPTH));
    assign rf_we     = (count != '0) && we_mem[rd_ptr];
    assign rf_addr   = rd_mem[rd_ptr];
    assign rf_data   = data_mem[rd_ptr];
    assign occupancy = count;

    assign push    = in_valid && in_ready;
    assign pop     = (count != '0) && (!we_mem[rd_ptr] || rf_ready);
    assign wr_fire = rf_we && rf_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (pop) begin
                rd_ptr      <= next_ptr(rd_ptr);
                vld[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr      <= next_ptr(wr_ptr);
                vld[wr_ptr] <= 1'b1;
            end
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
        end
    end

    // A flush discards the head, so its concurrent write is not credited.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ans_wb <= '0;
        else if (wr_fire && !flush)
            ans_wb <= rf_data;
    end

    // Entry payload is qualified by vld/count, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            data_mem[wr_ptr] <= in_sel ? in_ans_dm : in_ans_alu;
            rd_mem[wr_ptr]   <= in_rd;
            we_mem[wr_ptr]   <= in_we && (in_rd != '0);
        end
    end

    // Walk oldest to youngest so the last match is the youngest pending value.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[idx] && we_mem[idx] && (rd_mem[idx] == fwd_addr) && (fwd_addr != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[idx];
            end
            idx = next_ptr(idx);
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed plus random stimulus for writeback_queue, checked against a
// behavioural queue model kept as a scoreboard.
module tb_writeback_queue;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic              in_sel;
    logic [DATA_W-1:0] in_ans_alu;
    logic [DATA_W-1:0] in_ans_dm;
    logic [ADDR_W-1:0] in_rd;
    logic              in_we;
    logic              flush;
    logic              rf_we;
    logic              rf_ready;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic [ADDR_W-1:0] fwd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [DATA_W-1:0] ans_wb;
    logic [1:0]        occupancy;

    writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_ans_alu(in_ans_alu), .in_ans_dm(in_ans_dm), .in_rd(in_rd), .in_we(in_we),
        .flush(flush),
        .rf_we(rf_we), .rf_ready(rf_ready), .rf_addr(rf_addr), .rf_data(rf_data),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .ans_wb(ans_wb), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              we;
    } ent_t;

    ent_t              mq[$];
    logic [DATA_W-1:0] exp_ans;
    int                checks = 0;
    int                errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_ans_alu = '0;
        in_ans_dm  = '0;
        in_rd      = '0;
        in_we      = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic drive(input logic sel, input logic [7:0] alu, input logic [7:0] dm,
                         input logic [2:0] rd, input logic we);
        in_valid   = 1'b1;
        in_sel     = sel;
        in_ans_alu = alu;
        in_ans_dm  = dm;
        in_rd      = rd;
        in_we      = we;
    endtask

    // Check outputs mid-cycle against the model, then advance model and clock.
    task automatic cycle();
        ent_t              h;
        ent_t              n;
        bit                do_pop;
        int                sz;
        logic              ehit;
        logic [DATA_W-1:0] edata;
        @(negedge clk);
        sz    = mq.size();
        ehit  = 1'b0;
        edata = '0;
        for (int i = sz - 1; i >= 0; i--) begin
            if (!ehit && mq[i].we && mq[i].rd == fwd_addr && fwd_addr != '0) begin
                ehit  = 1'b1;
                edata = mq[i].data;
            end
        end
        chk("in_ready", in_ready, sz < DEPTH);
        chk("occupancy", occupancy, sz);
        chk("ans_wb", ans_wb, exp_ans);
        chk("fwd_hit", fwd_hit, ehit);
        chk("fwd_data", fwd_data, edata);
        do_pop = 1'b0;
        if (sz > 0) begin
            h = mq[0];
            chk("rf_we", rf_we, h.we);
            if (h.we) begin
                chk("rf_addr", rf_addr, h.rd);
                chk("rf_data", rf_data, h.data);
            end
            do_pop = !h.we || rf_ready;
        end else begin
            chk("rf_we_empty", rf_we, 0);
        end
        if (flush) begin
            mq.delete();
        end else begin
            if (do_pop) begin
                if (h.we && rf_ready) exp_ans = h.data;
                void'(mq.pop_front());
            end
            if (in_valid && sz < DEPTH) begin
                n.rd   = in_rd;
                n.data = in_sel ? in_ans_dm : in_ans_alu;
                n.we   = in_we && (in_rd != '0);
                mq.push_back(n);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        rf_ready = 1'b0;
        fwd_addr = '0;
        exp_ans  = '0;
        idle();
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_fwd_hit", fwd_hit, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_ans_wb", ans_wb, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic path
        rf_ready = 1'b1;
        drive(1'b0, 8'h3C, 8'h00, 3'd5, 1'b1);
        cycle();
        idle();
        chk("basic_rf_we", rf_we, 1);
        chk("basic_rf_addr", rf_addr, 5);
        chk("basic_rf_data", rf_data, 8'h3C);
        cycle();
        chk("basic_ans_wb", ans_wb, 8'h3C);
        chk("basic_occ", occupancy, 0);

        // Mux select and register zero
        drive(1'b1, 8'h00, 8'hA5, 3'd2, 1'b1);
        cycle();
        drive(1'b0, 8'h11, 8'h00, 3'd0, 1'b1);
        cycle();
        idle();
        chk("mux_ans_wb", ans_wb, 8'hA5);
        chk("r0_rf_we", rf_we, 0);
        cycle();
        chk("r0_ans_wb", ans_wb, 8'hA5);
        chk("r0_occ", occupancy, 0);

        // Backpressure and full
        rf_ready = 1'b0;
        drive(1'b0, 8'h01, 8'h00, 3'd1, 1'b1);
        cycle();
        drive(1'b0, 8'h02, 8'h00, 3'd4, 1'b1);
        cycle();
        chk("full_in_ready", in_ready, 0);
        chk("full_rf_data", rf_data, 8'h01);
        drive(1'b0, 8'h03, 8'h00, 3'd6, 1'b1);
        cycle();
        idle();
        chk("full_occ", occupancy, 2);
        chk("full_hold", rf_data, 8'h01);
        rf_ready = 1'b1;
        cycle();
        chk("drain1_ans", ans_wb, 8'h01);
        chk("drain1_next", rf_data, 8'h02);
        cycle();
        chk("drain2_ans", ans_wb, 8'h02);
        chk("drain2_occ", occupancy, 0);

        // Forwarding
        rf_ready = 1'b0;
        drive(1'b0, 8'h10, 8'h00, 3'd3, 1'b1);
        cycle();
        drive(1'b0, 8'h20, 8'h00, 3'd3, 1'b1);
        cycle();
        idle();
        fwd_addr = 3'd3;
        #1;
        chk("fwd_young_hit", fwd_hit, 1);
        chk("fwd_young_data", fwd_data, 8'h20);
        fwd_addr = 3'd0;
        #1;
        chk("fwd_r0_hit", fwd_hit, 0);
        chk("fwd_r0_data", fwd_data, 0);
        fwd_addr = 3'd3;
        rf_ready = 1'b1;
        cycle();
        cycle();
        chk("fwd_done_hit", fwd_hit, 0);
        chk("fwd_done_ans", ans_wb, 8'h20);

        // Flush with simultaneous push
        rf_ready = 1'b0;
        drive(1'b0, 8'h55, 8'h00, 3'd1, 1'b1);
        cycle();
        drive(1'b0, 8'h66, 8'h00, 3'd2, 1'b1);
        cycle();
        drive(1'b0, 8'h77, 8'h00, 3'd7, 1'b1);
        flush    = 1'b1;
        rf_ready = 1'b1;
        cycle();
        idle();
        chk("flush_occ", occupancy, 0);
        chk("flush_rf_we", rf_we, 0);
        chk("flush_ans", ans_wb, 8'h20);
        cycle();

        // Async reset while full
        rf_ready = 1'b0;
        drive(1'b0, 8'h99, 8'h00, 3'd3, 1'b1);
        cycle();
        drive(1'b0, 8'h88, 8'h00, 3'd4, 1'b1);
        cycle();
        idle();
        fwd_addr = 3'd3;
        #1;
        chk("pre_rst_hit", fwd_hit, 1);
        chk("pre_rst_occ", occupancy, 2);
        reset = 1'b1;
        #1;
        chk("arst_rf_we", rf_we, 0);
        chk("arst_fwd_hit", fwd_hit, 0);
        chk("arst_occ", occupancy, 0);
        chk("arst_ans", ans_wb, 0);
        chk("arst_in_ready", in_ready, 1);
        reset = 1'b0;
        mq.delete();
        exp_ans = '0;

        // Random traffic exercising pointer wrap, stalls and flushes
        for (int k = 0; k < 60; k++) begin
            idle();
            if ($urandom_range(0, 2) != 0)
                drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                      3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
            flush    = ($urandom_range(0, 19) == 0);
            rf_ready = 1'($urandom_range(0, 1));
            fwd_addr = 3'($urandom_range(0, 7));
            cycle();
        end
        idle();
        rf_ready = 1'b1;
        cycle();
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
Parametrised writeback stage for the pipelined MIPS datapath. It selects the ALU or data-memory result per instruction and queues retiring results in a small in-order FIFO. It drives the register-file write port with a valid/ready handshake and forwards pending (not yet written) results to decode. It keeps the registered ans_wb result output of the previous writeback block.

Parameters:
DATA_W, 8, width of result datapath
ADDR_W, 3, register-file address width (register 0 is hard-wired zero)
DEPTH, 2, queue entries; any integer >= 1, not required to be a power of two

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  retiring instruction present
in_ready  output  1  queue can accept an entry
in_sel  input  1  0 = ALU result, 1 = data-memory result
in_ans_alu  input  DATA_W  ALU result
in_ans_dm  input  DATA_W  data-memory result
in_rd  input  ADDR_W  destination register
in_we  input  1  instruction writes a register
flush  input  1  synchronous discard of all queued entries
rf_we  output  1  register-file write request (valid)
rf_ready  input  1  register-file write port accepts this cycle
rf_addr  output  ADDR_W  write address (head entry)
rf_data  output  DATA_W  write data (head entry)
fwd_addr  input  ADDR_W  decode source register to look up
fwd_hit  output  1  a pending write to fwd_addr is queued
fwd_data  output  DATA_W  youngest pending value for fwd_addr
ans_wb  output  DATA_W  last value written to the register file
occupancy  output  ceil(log2(DEPTH+1))  entries held

Behaviour:
- Reset (async, high): wr_ptr = rd_ptr = count = 0, all entry valid bits 0, ans_wb = 0, rf_we = 0, fwd_hit = 0, in_ready = 1. Entry data need not be reset.
- Push: when in_valid && in_ready at the edge, store {data, rd, we} at wr_ptr.
  - data = in_sel ? in_ans_dm : in_ans_alu.
  - Effective we = in_we && (in_rd != 0).
- in_ready = (count < DEPTH). It depends only on state, so there is no combinational path from rf_ready. When full, a same-cycle pop does not enable a push.
- Head output: rf_we = (count > 0) && head.we. rf_addr and rf_data come from the head entry. They hold stable while rf_we && !rf_ready.
- Pop:
  - When count > 0 and (head.we == 0 or rf_ready == 1), rd_ptr advances at the edge.
  - Entries with we = 0 retire in one cycle without a write.
- ans_wb updates to rf_data only on an actual write handshake (rf_we && rf_ready). Otherwise it holds.
- Latency: an entry pushed into an empty queue at edge N is presented on rf_* during cycle N+1. It writes at edge N+1 if rf_ready = 1. There is no bypass from input to rf_*.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointer wrap: a pointer at DEPTH-1 advances to 0.
- Forwarding (combinational on fwd_addr):
  - fwd_hit = 1 if any valid entry has we = 1 and rd == fwd_addr, and fwd_addr != 0.
  - fwd_data is the youngest such entry, in age order from wr_ptr-1 back to rd_ptr.
  - The head entry counts as pending until its write handshake completes.
  - fwd_data = 0 when fwd_hit = 0.
- Flush: at the edge, count = 0, pointers = 0, valid bits cleared.
  - Flush overrides any push or pop in the same cycle, and no write handshake is credited.
  - ans_wb holds its value.
  - Combinationally, rf_we still reflects the pre-flush state during the flush cycle. The bench must accept the register-file write that cycle if rf_ready = 1; ans_wb does not update.
- Reset asserted mid-operation clears immediately, asynchronously. Outputs return to reset values without waiting for a clock edge.

Test Plan:
- Reset then basic path: push {sel=0, alu=0x3C, rd=5, we=1}, rf_ready=1 -> next cycle rf_we=1, rf_addr=5, rf_data=0x3C; ans_wb=0x3C after that edge; occupancy back to 0.
- Mux and $0: push {sel=1, dm=0xA5, rd=2}, then {rd=0, we=1, alu=0x11} -> first writes 0xA5 to r2; second retires with rf_we=0 and ans_wb stays 0xA5.
- Backpressure/full (DEPTH=2): rf_ready=0, push 0x01 and then 0x02 -> in_ready=0 after the 2nd push; rf_data holds 0x01; a third push is ignored; releasing rf_ready writes 0x01 then 0x02 on consecutive cycles.
- Forwarding: queue r3=0x10 then r3=0x20 with rf_ready=0, fwd_addr=3 -> fwd_hit=1, fwd_data=0x20; fwd_addr=0 -> fwd_hit=0; after both writes complete -> fwd_hit=0.
- Flush with simultaneous push: two entries queued, flush=1 and in_valid=1 in the same cycle -> occupancy=0, rf_we=0 next cycle, ans_wb unchanged.
- Async reset mid-stall: reset pulse between clock edges while full -> rf_we, fwd_hit, occupancy and ans_wb go to 0 before the next edge; in_ready=1.
